// File: rtl/spi_txn_sequencer.sv
// Purpose: queues SPI commands and runs them one at a time on the SPI master, returning rdata + status.
// Latency: pop edge -> spi_start 1 cycle; spi_finished -> rsp_valid 1 cycle; timeout TIMEOUT_CYC cycles into WAIT.
// Backpressure: cmd_ready low while the FIFO is full; no pop while master busy or a response is pending.
module spi_txn_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 2048
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [63:0]                   cmd_wdata,
    input  logic [2:0]                    cmd_bytes,
    input  logic [1:0]                    cmd_mode,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [63:0]                   rsp_rdata,
    output logic [1:0]                    rsp_status,
    output logic                          spi_start,
    output logic [63:0]                   spi_data,
    output logic [2:0]                    spi_byte_num,
    output logic [1:0]                    spi_mode,
    input  logic                          spi_busy,
    input  logic                          spi_finished,
    input  logic [63:0]                   spi_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BAD_LEN = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t        state;
    logic [68:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    logic [68:0]   head;
    logic [CW-1:0] to_cnt;
    logic [63:0]   rx_mask;

    assign empty      = (count == '0);
    assign full       = (count == DEPTH_L);
    assign cmd_ready  = !full;
    assign push       = cmd_valid && cmd_ready;
    // rsp_valid is always low in IDLE; kept in the term so a pending response can never be overtaken
    assign pop        = (state == IDLE) && !empty && !spi_busy && !rsp_valid;
    assign head       = mem[rd_ptr];
    assign fifo_level = count;
    assign idle       = empty && (state == IDLE);
    // Keep only the 8*bytes low bits of the received word
    assign rx_mask    = ~(64'hFFFF_FFFF_FFFF_FFFF << {spi_byte_num, 3'b000});

    // FIFO storage; validity is defined by the pointers, so the array itself is not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_mode, cmd_bytes, cmd_wdata};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Transaction FSM with registered master-side and response-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            spi_start    <= 1'b0;
            spi_data     <= '0;
            spi_byte_num <= '0;
            spi_mode     <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_status   <= '0;
            to_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        {spi_mode, spi_byte_num, spi_data} <= head;
                        if (head[66:64] == 3'd0) begin
                            // Zero-length command is answered without touching the master
                            rsp_rdata  <= '0;
                            rsp_status <= ST_BAD_LEN;
                            rsp_valid  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            spi_start <= 1'b1;
                            state     <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    spi_start <= 1'b0;
                    to_cnt    <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (spi_finished) begin
                        rsp_rdata  <= spi_rdata & rx_mask;
                        rsp_status <= ST_OK;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (to_cnt == TO_LAST) begin
                        rsp_rdata  <= '0;
                        rsp_status <= ST_TIMEOUT;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Bench for spi_txn_sequencer: behavioural SPI master plus queue-based response model.
// Latency and timeout checks are measured in clk cycles counted by the bench.
// Response backpressure is driven both held-high and randomly throttled.
module tb_spi_txn_sequencer;

    localparam int DEPTH = 4;
    localparam int TO    = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_wdata = '0;
    logic [2:0]  cmd_bytes = '0;
    logic [1:0]  cmd_mode = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        spi_start;
    logic [63:0] spi_data;
    logic [2:0]  spi_byte_num;
    logic [1:0]  spi_mode;
    logic        spi_busy = 1'b0;
    logic        spi_finished = 1'b0;
    logic [63:0] spi_rdata = '0;
    logic [2:0]  fifo_level;
    logic        idle;

    spi_txn_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wdata(cmd_wdata),
        .cmd_bytes(cmd_bytes), .cmd_mode(cmd_mode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status),
        .spi_start(spi_start), .spi_data(spi_data), .spi_byte_num(spi_byte_num),
        .spi_mode(spi_mode), .spi_busy(spi_busy), .spi_finished(spi_finished),
        .spi_rdata(spi_rdata), .fifo_level(fifo_level), .idle(idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [63:0] wdata; logic [2:0] bytes; logic [1:0] mode; } cmd_t;
    typedef struct { logic [63:0] reply; bit hung; } rep_t;

    cmd_t mq[$];   // every accepted command, in order
    cmd_t lq[$];   // commands expected to reach the master
    rep_t rq[$];   // what the master answered for each launch

    int vectors = 0;
    int miscompares = 0;
    int viol = 0;
    int starts = 0;

    // master model controls
    bit          m_hang = 0;
    bit          m_abort = 0;
    bit          m_hold = 0;
    bit          m_fixed_en = 0;
    logic [63:0] m_fixed = '0;
    int          m_fin_cyc = 0;
    int          m_start_cyc = 0;

    bit          m_act = 0;
    bit          m_fin_d = 0;
    bit          m_cur_hung = 0;
    int          m_left = 0;
    logic [1:0]  m_mode = '0;
    logic [63:0] m_cur = '0;

    // Behavioural SPI master: busy from start until the edge after finished, random transfer time
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_fin_d = 0; spi_finished = 0; spi_busy = 0;
        end else begin
            cmd_t e;
            rep_t r;
            if (m_fin_d) begin m_act = 0; m_fin_d = 0; end
            spi_finished = 0;
            spi_rdata = {$urandom, $urandom};
            if (m_abort) m_act = 0;
            if (spi_start) begin
                starts++;
                if (spi_busy) viol++;
                if (lq.size() == 0) viol++;
                else begin
                    e = lq.pop_front();
                    if (spi_data !== e.wdata || spi_byte_num !== e.bytes || spi_mode !== e.mode) viol++;
                end
                r.reply = m_fixed_en ? m_fixed : {$urandom, $urandom};
                r.hung = m_hang;
                rq.push_back(r);
                m_act = 1; m_cur = r.reply; m_cur_hung = m_hang; m_mode = spi_mode;
                m_left = $urandom_range(1, 12); m_start_cyc = cyc;
            end else if (m_act && !m_cur_hung && !m_fin_d) begin
                m_left--;
                if (m_left == 0) begin
                    spi_finished = 1; spi_rdata = m_cur; m_fin_d = 1; m_fin_cyc = cyc;
                end
            end
            if (m_act && spi_mode !== m_mode) viol++;
            spi_busy = m_act || m_hold;
        end
    end

    function automatic logic [63:0] byte_mask(input logic [2:0] b);
        return (64'd1 << (8 * b)) - 64'd1;
    endfunction

    // Reference model: next expected response from the command and reply queues
    task automatic exp_next(output logic [63:0] d, output logic [1:0] s);
        cmd_t c;
        rep_t r;
        d = 'x; s = 2'b11;
        if (mq.size() == 0) return;
        c = mq.pop_front();
        if (c.bytes == 0) begin d = '0; s = 2'b01; end
        else if (rq.size() != 0) begin
            r = rq.pop_front();
            if (r.hung) begin d = '0; s = 2'b10; end
            else begin d = r.reply & byte_mask(c.bytes); s = 2'b00; end
        end
    endtask

    // Drive one command; entered just after a negedge, returns at the negedge after acceptance
    task automatic push_cmd(input logic [63:0] d, input logic [2:0] b, input logic [1:0] m);
        cmd_t c;
        int n = 0;
        c.wdata = d; c.bytes = b; c.mode = m;
        cmd_wdata = d; cmd_bytes = b; cmd_mode = m; cmd_valid = 1;
        while (!cmd_ready && n < 5000) begin @(negedge clk); n++; end
        if (cmd_ready) begin
            mq.push_back(c);
            if (b != 0) lq.push_back(c);
        end
        @(negedge clk);
        cmd_valid = 0;
    endtask

    // Collect one response handshake (bounded wait)
    task automatic get_rsp(input bit rnd, output logic [63:0] d, output logic [1:0] s, output bit ok);
        int n = 0;
        ok = 0; d = '0; s = '0;
        while (n < 3000) begin
            rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rsp_valid && rsp_ready) begin
                d = rsp_rdata; s = rsp_status; ok = 1;
                @(posedge clk); @(negedge clk);
                break;
            end
            @(negedge clk); n++;
        end
        rsp_ready = 0;
    endtask

    task automatic wait_rsp_valid(input int lim, output bit ok);
        int n = 0;
        while (!rsp_valid && n < lim) begin @(negedge clk); n++; end
        ok = rsp_valid;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        vectors++;
        if ({cmd_ready, idle, rsp_valid, spi_start} !== 4'b1100) begin
            miscompares++; $display("FAIL reset_flags got %b want 1100", {cmd_ready, idle, rsp_valid, spi_start});
        end
        vectors++;
        if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        vectors++;
        if ({spi_data, spi_byte_num, spi_mode} !== 69'd0) begin
            miscompares++; $display("FAIL reset_spi_out got %h/%0d/%0d want 0", spi_data, spi_byte_num, spi_mode);
        end
        vectors++;
        if ({rsp_rdata, rsp_status} !== 66'd0) begin
            miscompares++; $display("FAIL reset_rsp got %h/%0d want 0", rsp_rdata, rsp_status);
        end
    endtask

    task automatic test_single;
        logic [63:0] d, ed; logic [1:0] s, es; bit ok; int s0;
        m_fixed_en = 1; m_fixed = 64'h3C5A; s0 = starts;
        push_cmd(64'hA5C3, 3'd2, 2'd0);
        wait_rsp_valid(500, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL single_rsp_valid got 0 want 1"); end
        vectors++;
        if (cyc !== m_fin_cyc + 1) begin
            miscompares++; $display("FAIL single_latency got %0d want %0d", cyc - m_fin_cyc, 1);
        end
        vectors++;
        if (rsp_rdata !== 64'h3C5A || rsp_status !== 2'b00) begin
            miscompares++; $display("FAIL single_data got %h/%0d want 3c5a/0", rsp_rdata, rsp_status);
        end
        get_rsp(0, d, s, ok); exp_next(ed, es);
        vectors++;
        if (!ok || d !== ed || s !== es) begin miscompares++; $display("FAIL single_model got %h/%0d want %h/%0d", d, s, ed, es); end
        repeat (3) @(negedge clk);
        vectors++;
        if (starts - s0 !== 1) begin miscompares++; $display("FAIL single_starts got %0d want 1", starts - s0); end
        m_fixed_en = 0;
    endtask

    task automatic test_back_to_back;
        logic [63:0] d, ed; logic [1:0] s, es; bit ok;
        logic [2:0] bl [4];
        bl[0] = 3'd1; bl[1] = 3'd3; bl[2] = 3'd7; bl[3] = 3'd2;
        m_hold = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) push_cmd({$urandom, $urandom}, bl[i], 2'(i));
        vectors++;
        if (cmd_ready !== 1'b0 || fifo_level !== 3'd4) begin
            miscompares++; $display("FAIL b2b_full got ready=%b level=%0d want ready=0 level=4", cmd_ready, fifo_level);
        end
        m_hold = 0;
        for (int i = 0; i < 4; i++) begin
            get_rsp(0, d, s, ok); exp_next(ed, es);
            vectors++;
            if (!ok || d !== ed || s !== es) begin
                miscompares++; $display("FAIL b2b_rsp%0d got %h/%0d want %h/%0d", i, d, s, ed, es);
            end
        end
        vectors++;
        if (viol !== 0) begin miscompares++; $display("FAIL b2b_master_rules got %0d violations want 0", viol); end
    endtask

    task automatic test_bad_length;
        logic [63:0] d, ed; logic [1:0] s, es; bit ok; int s0;
        repeat (3) @(negedge clk);
        s0 = starts;
        push_cmd({$urandom, $urandom}, 3'd0, 2'd1);
        push_cmd({$urandom, $urandom}, 3'd4, 2'd2);
        for (int i = 0; i < 2; i++) begin
            get_rsp(0, d, s, ok); exp_next(ed, es);
            vectors++;
            if (!ok || d !== ed || s !== es) begin
                miscompares++; $display("FAIL badlen_rsp%0d got %h/%0d want %h/%0d", i, d, s, ed, es);
            end
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (starts - s0 !== 1) begin miscompares++; $display("FAIL badlen_starts got %0d want 1", starts - s0); end
    endtask

    task automatic test_timeout;
        logic [63:0] d, ed; logic [1:0] s, es; bit ok; int s0;
        m_hang = 1;
        push_cmd({$urandom, $urandom}, 3'd5, 2'd3);
        wait_rsp_valid(600, ok);
        m_hang = 0;
        vectors++;
        if (!ok || cyc - m_start_cyc !== TO + 1) begin
            miscompares++; $display("FAIL timeout_cycles got %0d want %0d", cyc - m_start_cyc - 1, TO);
        end
        get_rsp(0, d, s, ok); exp_next(ed, es);
        vectors++;
        if (!ok || d !== 64'd0 || s !== 2'b10 || s !== es) begin
            miscompares++; $display("FAIL timeout_rsp got %h/%0d want 0/2", d, s);
        end
        s0 = starts;
        push_cmd({$urandom, $urandom}, 3'd1, 2'd0);
        repeat (20) @(negedge clk);
        vectors++;
        if (starts !== s0 || fifo_level !== 3'd1) begin
            miscompares++; $display("FAIL timeout_busy_stall got starts+%0d level=%0d want +0 level=1", starts - s0, fifo_level);
        end
        m_abort = 1;
        repeat (2) @(negedge clk);
        m_abort = 0;
        get_rsp(0, d, s, ok); exp_next(ed, es);
        vectors++;
        if (!ok || d !== ed || s !== es) begin miscompares++; $display("FAIL timeout_next got %h/%0d want %h/%0d", d, s, ed, es); end
    endtask

    task automatic test_mask_hold;
        logic [63:0] d, ed, d0; logic [1:0] s, es; bit ok, stable; int s0;
        m_fixed_en = 1; m_fixed = '1; rsp_ready = 0;
        push_cmd({$urandom, $urandom}, 3'd3, 2'd1);
        push_cmd({$urandom, $urandom}, 3'd6, 2'd0);
        wait_rsp_valid(500, ok);
        d0 = rsp_rdata; s0 = starts; stable = ok;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== d0) stable = 0;
        end
        vectors++;
        if (d0 !== 64'h0000_0000_00FF_FFFF) begin miscompares++; $display("FAIL mask_rdata got %h want 0000000000ffffff", d0); end
        vectors++;
        if (!stable || starts !== s0 || fifo_level !== 3'd1) begin
            miscompares++; $display("FAIL hold_stable got stable=%b starts+%0d level=%0d want 1/+0/1", stable, starts - s0, fifo_level);
        end
        for (int i = 0; i < 2; i++) begin
            get_rsp(0, d, s, ok); exp_next(ed, es);
            vectors++;
            if (!ok || d !== ed || s !== es) begin
                miscompares++; $display("FAIL mask_rsp%0d got %h/%0d want %h/%0d", i, d, s, ed, es);
            end
        end
        m_fixed_en = 0;
    endtask

    task automatic test_random;
        localparam int N = 40;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    logic [2:0] b;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    b = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
                    push_cmd({$urandom, $urandom}, b, 2'($urandom_range(0, 3)));
                end
            end
            begin
                for (int i = 0; i < N; i++) begin
                    logic [63:0] d, ed; logic [1:0] s, es; bit ok;
                    get_rsp(1, d, s, ok); exp_next(ed, es);
                    vectors++;
                    if (!ok || d !== ed || s !== es) begin
                        miscompares++; $display("FAIL random_rsp%0d got %h/%0d want %h/%0d", i, d, s, ed, es);
                    end
                end
            end
        join
        vectors++;
        if (viol !== 0) begin miscompares++; $display("FAIL random_master_rules got %0d violations want 0", viol); end
    endtask

    task automatic test_reset_mid;
        logic [63:0] d, ed; logic [1:0] s, es; bit ok; int n = 0; int s0;
        m_hang = 1; s0 = starts;
        for (int i = 0; i < 3; i++) push_cmd({$urandom, $urandom}, 3'd2, 2'd2);
        while (starts == s0 && n < 200) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        vectors++;
        if (fifo_level !== 3'd2 || spi_busy !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_setup got level=%0d busy=%b want 2/1", fifo_level, spi_busy);
        end
        #2 rst_n = 0;
        #1;
        vectors++;
        if ({spi_start, rsp_valid, cmd_ready, idle} !== 4'b0011 || fifo_level !== 3'd0) begin
            miscompares++; $display("FAIL rstmid_async got %b level=%0d want 0011 level=0", {spi_start, rsp_valid, cmd_ready, idle}, fifo_level);
        end
        m_hang = 0;
        mq.delete(); lq.delete(); rq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        vectors++;
        if ({cmd_ready, idle, rsp_valid, spi_start} !== 4'b1100 || fifo_level !== 3'd0) begin
            miscompares++; $display("FAIL rstmid_after got %b level=%0d want 1100 level=0", {cmd_ready, idle, rsp_valid, spi_start}, fifo_level);
        end
        push_cmd({$urandom, $urandom}, 3'd7, 2'd1);
        get_rsp(0, d, s, ok); exp_next(ed, es);
        vectors++;
        if (!ok || d !== ed || s !== es) begin miscompares++; $display("FAIL rstmid_next got %h/%0d want %h/%0d", d, s, ed, es); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_length();
        test_timeout();
        test_mask_hold();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete at time %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/spi_txn_sequencer.md
Name: spi_txn_sequencer

Overview:
- Command front-end that sits directly upstream of the SPI master and feeds it.
- Queues SPI transactions from a valid/ready command port and launches them on the master one at a time.
- Uses the master's start/busy/finished handshake; captures the master's received data and returns it on a valid/ready response port with a status code.
- Provides length checking and a finish timeout, so a stalled master cannot hang the host.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2
TIMEOUT_CYC, 2048, clk cycles allowed in WAIT before timeout; must be greater than 7*16+4

Ports:
clk  in  1  system clock, same clock as the SPI master
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command FIFO not full
cmd_wdata  in  64  tx data, LSB-aligned; bit 8*bytes-1 is sent first
cmd_bytes  in  3  transfer length in bytes, 1..7; 0 is illegal
cmd_mode  in  2  SPI mode {CPOL,CPHA}
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_rdata  out  64  received data, LSB-aligned, bits above 8*bytes zero
rsp_status  out  2  00 ok, 01 bad length, 10 timeout
spi_start  out  1  start pulse to the master
spi_data  out  64  tx data to the master
spi_byte_num  out  3  byte count to the master
spi_mode  out  2  mode to the master
spi_busy  in  1  master busy
spi_finished  in  1  master one-cycle done pulse
spi_rdata  in  64  master received data
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
idle  out  1  high when FIFO is empty and state is IDLE

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1 and idle=1. FIFO empty, state IDLE. spi_data, spi_byte_num and spi_mode are 0.
- FIFO:
  - Push on cmd_valid&&cmd_ready. cmd_ready = !full.
  - Push and pop in the same cycle are legal; level is unchanged.
  - A push while full is impossible, because ready is low.
  - Pointers wrap modulo FIFO_DEPTH.
  - Each entry holds wdata, bytes and mode (69 bits).
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - Pops only when the FIFO is non-empty, spi_busy==0 and rsp_valid==0.
  - On the pop edge, the entry is latched into spi_data, spi_byte_num and spi_mode.
  - If bytes==0: go to RESP with status 01 and rdata 0. No spi_start is issued.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - spi_start=1 for exactly one cycle (spi_start = state==LAUNCH). Go to WAIT next edge.
  - The timeout counter is cleared on entry to WAIT.
- WAIT:
  - spi_data, spi_byte_num and spi_mode are held stable.
  - Counter increments every cycle.
  - If spi_finished: capture spi_rdata masked to 8*bytes bits, set status 00, go to RESP.
  - Else if the counter reaches TIMEOUT_CYC-1: set rdata 0, status 10, go to RESP.
  - If finished and the timeout limit occur in the same cycle, finished wins.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_status are stable until the handshake.
  - On rsp_ready go to IDLE; rsp_valid drops the next cycle.
- Latency:
  - Pop edge to spi_start high: 1 cycle.
  - spi_finished to rsp_valid: 1 cycle.
  - Back-to-back commands: the next launch waits for spi_busy==0, which the master clears the edge after finished.
- Master-port rules:
  - spi_rdata is sampled only in the cycle spi_finished=1.
  - spi_finished outside WAIT is ignored.
  - spi_mode changes only on the IDLE pop edge, never during a transfer.
- After a timeout, the next launch still waits for spi_busy==0. A permanently busy master therefore stalls the queue but never issues a start into a busy master.
- Reset mid-operation: all state is returned to reset values asynchronously, the FIFO is flushed and spi_start is deasserted immediately. An in-flight response is lost.
- Masking: rsp_rdata[63:8*bytes] = 0. spi_data passes the full 64-bit entry unmodified.

Test Plan:
- Single command, mode 0, bytes=2, wdata=0xA5C3, loopback master returns 0x3C5A → exactly one spi_start pulse; rsp_valid with rdata=0x0000_3C5A and status 00 one cycle after finished.
- Push 4 commands back-to-back (bytes 1,3,7,2), modes 0..3, with rsp_ready held high → cmd_ready low after the 4th push; 4 responses in order; each spi_start occurs only with spi_busy=0; spi_mode is stable throughout each transfer.
- Command with bytes=0 → no spi_start; rsp_status=01, rsp_rdata=0; the next queued command proceeds normally.
- Master model never asserts finished, TIMEOUT_CYC=256 → rsp_status=10 exactly 256 cycles after entering WAIT; rdata=0.
- spi_rdata=all ones, bytes=3 → rsp_rdata=0x0000_0000_00FF_FFFF. Separately, hold rsp_ready low for 20 cycles → no new pop, data stable.
- Assert rst_n low mid-WAIT with 2 entries queued → after release: fifo_level=0, idle=1, rsp_valid=0, spi_start=0, cmd_ready=1.
